// File: rtl/bin_bcd_seq.sv
// Iterative binary-to-BCD converter (shift-and-add-3), one input bit per clock,
// with valid/ready on both sides, leading-zero blanking and overflow saturation.
module bin_bcd_seq #(
    parameter int BIN_W  = 12,
    parameter int DIGITS = 4
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [BIN_W-1:0]    bin,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [4*DIGITS-1:0] bcd,
    output logic [DIGITS-1:0]   blank,
    output logic                ovf,
    output logic                busy
);

    localparam int BCD_W = 4 * DIGITS;
    localparam int SR_W  = BCD_W + BIN_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(BIN_W - 1);
    // 2^BIN_W <= 10^DIGITS  <=>  BIN_W <= DIGITS*log2(10); then overflow is impossible
    localparam bit FITS = (longint'(BIN_W) * 1000000) <= (longint'(DIGITS) * 3321928);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_SHIFT = 2'd1,
        S_DONE  = 2'd2
    } state_t;

    state_t             r_state;
    logic [SR_W-1:0]    r_sr;
    logic [CNT_W-1:0]   r_cnt;
    logic               r_ovf_acc;
    logic               r_out_valid;
    logic [BCD_W-1:0]   r_bcd;
    logic [DIGITS-1:0]  r_blank;
    logic               r_ovf;
    logic               r_busy;

    logic [SR_W-1:0]    w_adj;
    logic [SR_W-1:0]    w_shift;
    logic               w_top;
    logic [BCD_W-1:0]   w_dig;
    logic [DIGITS-1:0]  w_dig_bad;
    logic [DIGITS-1:0]  w_blank;
    logic               w_zero_run;
    logic               w_ovf;
    logic [BCD_W-1:0]   w_sat;

    assign w_adj[BIN_W-1:0] = r_sr[BIN_W-1:0];

    genvar gi;
    generate
        for (gi = 0; gi < DIGITS; gi++) begin : g_digit
            logic [3:0] w_cur;
            assign w_cur = r_sr[BIN_W + 4*gi +: 4];
            assign w_adj[BIN_W + 4*gi +: 4] = (w_cur >= 4'd5) ? (w_cur + 4'd3) : w_cur;
            assign w_dig_bad[gi] = (w_dig[4*gi +: 4] > 4'd9);
            assign w_sat[4*gi +: 4] = 4'h9;
        end
    endgenerate

    assign w_shift = {w_adj[SR_W-2:0], 1'b0};
    assign w_top   = w_adj[SR_W-1];
    assign w_dig   = w_shift[SR_W-1 -: BCD_W];
    assign w_ovf   = !FITS && (r_ovf_acc || w_top || (|w_dig_bad));

    // Walk down from the top digit; a digit is blanked while everything above it is zero
    always_comb begin
        w_blank    = '0;
        w_zero_run = 1'b1;
        for (int i = DIGITS - 1; i >= 1; i--) begin
            w_zero_run = w_zero_run & (w_dig[4*i +: 4] == 4'd0);
            w_blank[i] = w_zero_run;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_sr        <= '0;
            r_cnt       <= '0;
            r_ovf_acc   <= 1'b0;
            r_out_valid <= 1'b0;
            r_bcd       <= '0;
            r_blank     <= '0;
            r_ovf       <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_sr      <= {{BCD_W{1'b0}}, bin};
                        r_cnt     <= '0;
                        r_ovf_acc <= 1'b0;
                        r_busy    <= 1'b1;
                        r_state   <= S_SHIFT;
                    end
                end
                S_SHIFT: begin
                    r_sr      <= w_shift;
                    r_ovf_acc <= r_ovf_acc | w_top;
                    r_cnt     <= r_cnt + CNT_W'(1);
                    if (r_cnt == LAST_STEP) begin
                        r_busy      <= 1'b0;
                        r_out_valid <= 1'b1;
                        r_bcd       <= w_ovf ? w_sat : w_dig;
                        r_blank     <= w_ovf ? '0 : w_blank;
                        r_ovf       <= w_ovf;
                        r_state     <= S_DONE;
                    end
                end
                S_DONE: begin
                    if (out_ready) begin
                        r_out_valid <= 1'b0;
                        if (in_valid) begin
                            r_sr      <= {{BCD_W{1'b0}}, bin};
                            r_cnt     <= '0;
                            r_ovf_acc <= 1'b0;
                            r_busy    <= 1'b1;
                            r_state   <= S_SHIFT;
                        end else begin
                            r_state   <= S_IDLE;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign in_ready  = (r_state == S_IDLE) || ((r_state == S_DONE) && out_ready);
    assign out_valid = r_out_valid;
    assign bcd       = r_bcd;
    assign blank     = r_blank;
    assign ovf       = r_ovf;
    assign busy      = r_busy;

endmodule

// File: tb/tb_bin_bcd_seq.sv
// Self-checking bench for bin_bcd_seq: a default 12-bit/4-digit instance and a
// 14-bit/4-digit instance, checked against a decimal arithmetic reference model.
module tb_bin_bcd_seq;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        in_valid;
    logic        out_ready;
    logic [13:0] bin;

    logic        a_in_valid, a_out_ready, a_in_ready, a_out_valid, a_ovf, a_busy;
    logic [15:0] a_bcd;
    logic [3:0]  a_blank;
    logic        b_in_valid, b_out_ready, b_in_ready, b_out_valid, b_ovf, b_busy;
    logic [15:0] b_bcd;
    logic [3:0]  b_blank;

    logic        m_in_ready, m_out_valid, m_ovf, m_busy;
    logic [15:0] m_bcd;
    logic [3:0]  m_blank;

    int checks = 0;
    int errors = 0;

    assign a_in_valid  = in_valid & ~sel;
    assign a_out_ready = out_ready & ~sel;
    assign b_in_valid  = in_valid & sel;
    assign b_out_ready = out_ready & sel;

    assign m_in_ready  = sel ? b_in_ready  : a_in_ready;
    assign m_out_valid = sel ? b_out_valid : a_out_valid;
    assign m_bcd       = sel ? b_bcd       : a_bcd;
    assign m_blank     = sel ? b_blank     : a_blank;
    assign m_ovf       = sel ? b_ovf       : a_ovf;
    assign m_busy      = sel ? b_busy      : a_busy;

    bin_bcd_seq #(.BIN_W(12), .DIGITS(4)) dut_a (
        .clk(clk), .rst_n(rst_n),
        .in_valid(a_in_valid), .in_ready(a_in_ready), .bin(bin[11:0]),
        .out_valid(a_out_valid), .out_ready(a_out_ready),
        .bcd(a_bcd), .blank(a_blank), .ovf(a_ovf), .busy(a_busy)
    );

    bin_bcd_seq #(.BIN_W(14), .DIGITS(4)) dut_b (
        .clk(clk), .rst_n(rst_n),
        .in_valid(b_in_valid), .in_ready(b_in_ready), .bin(bin),
        .out_valid(b_out_valid), .out_ready(b_out_ready),
        .bcd(b_bcd), .blank(b_blank), .ovf(b_ovf), .busy(b_busy)
    );

    // Reference: plain decimal arithmetic on the value
    function automatic void model(input int unsigned v, output logic [15:0] e_bcd,
                                  output logic [3:0] e_blank, output logic e_ovf);
        int unsigned t;
        if (v > 9999) begin
            e_bcd = 16'h9999; e_blank = 4'b0000; e_ovf = 1'b1;
        end else begin
            e_ovf = 1'b0;
            e_bcd = '0;
            t = v;
            for (int i = 0; i < 4; i++) begin
                e_bcd[4*i +: 4] = 4'(t % 10);
                t = t / 10;
            end
            e_blank[0] = 1'b0;
            e_blank[1] = (v < 10);
            e_blank[2] = (v < 100);
            e_blank[3] = (v < 1000);
        end
    endfunction

    // Called at a negedge; returns at the first negedge with out_valid high (or after a bound)
    task automatic start_conv(input bit use_b, input int unsigned v, output int lat);
        sel = use_b; bin = 14'(v); in_valid = 1'b1; out_ready = 1'b0;
        for (int i = 0; i < 50 && !m_in_ready; i++) @(negedge clk);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (!m_out_valid && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic take_result();
        out_ready = 1'b1;
        @(negedge clk);
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b1; out_ready = 1'b1; bin = 14'd5;
        repeat (3) @(negedge clk);
        checks++; if (a_out_valid !== 1'b0) begin errors++; $display("FAIL reset_a_out_valid got=%b exp=0", a_out_valid); end
        checks++; if (a_bcd !== 16'h0000) begin errors++; $display("FAIL reset_a_bcd got=%h exp=0000", a_bcd); end
        checks++; if (a_blank !== 4'b0000) begin errors++; $display("FAIL reset_a_blank got=%b exp=0000", a_blank); end
        checks++; if (a_ovf !== 1'b0) begin errors++; $display("FAIL reset_a_ovf got=%b exp=0", a_ovf); end
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_a_busy got=%b exp=0", a_busy); end
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL reset_a_in_ready got=%b exp=1", a_in_ready); end
        checks++; if (b_out_valid !== 1'b0 || b_busy !== 1'b0) begin errors++; $display("FAIL reset_b_state got valid=%b busy=%b exp 0 0", b_out_valid, b_busy); end
        checks++; if (b_in_ready !== 1'b1) begin errors++; $display("FAIL reset_b_in_ready got=%b exp=1", b_in_ready); end
        in_valid = 1'b0; out_ready = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++; if (a_busy !== 1'b0) begin errors++; $display("FAIL reset_no_handshake busy got=%b exp=0", a_busy); end
        $display("reset done");
    endtask

    task automatic test_conversion();
        int unsigned vals[$];
        int lat;
        logic [15:0] e_bcd; logic [3:0] e_blank; logic e_ovf;
        vals = '{0, 4095, 7, 80, 9, 10, 999, 1000};
        for (int i = 0; i < 12; i++) vals.push_back($urandom_range(4095, 0));
        foreach (vals[k]) begin
            model(vals[k], e_bcd, e_blank, e_ovf);
            start_conv(1'b0, vals[k], lat);
            $display("conv12 bin=%0d bcd=%h blank=%b ovf=%b lat=%0d", vals[k], m_bcd, m_blank, m_ovf, lat);
            checks++; if (lat !== 12) begin errors++; $display("FAIL conv_latency bin=%0d got=%0d exp=12", vals[k], lat); end
            checks++; if (m_bcd !== e_bcd) begin errors++; $display("FAIL conv_bcd bin=%0d got=%h exp=%h", vals[k], m_bcd, e_bcd); end
            checks++; if (m_blank !== e_blank) begin errors++; $display("FAIL conv_blank bin=%0d got=%b exp=%b", vals[k], m_blank, e_blank); end
            checks++; if (m_ovf !== e_ovf) begin errors++; $display("FAIL conv_ovf bin=%0d got=%b exp=%b", vals[k], m_ovf, e_ovf); end
            take_result();
        end
    endtask

    task automatic test_backpressure();
        int lat;
        logic [15:0] e_bcd; logic [3:0] e_blank; logic e_ovf;
        model(1234, e_bcd, e_blank, e_ovf);
        start_conv(1'b0, 1234, lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL bp_latency got=%0d exp=12", lat); end
        for (int c = 0; c < 5; c++) begin
            in_valid = (c % 2 == 0);
            bin = 14'(c * 111 + 3);
            #1;
            checks++; if (a_in_ready !== 1'b0) begin errors++; $display("FAIL bp_in_ready cyc=%0d got=%b exp=0", c, a_in_ready); end
            @(negedge clk);
            checks++; if (a_out_valid !== 1'b1 || a_bcd !== e_bcd || a_blank !== e_blank || a_ovf !== e_ovf || a_busy !== 1'b0)
                begin errors++; $display("FAIL bp_hold cyc=%0d got v=%b bcd=%h blank=%b ovf=%b busy=%b exp v=1 bcd=%h blank=%b ovf=%b busy=0",
                                         c, a_out_valid, a_bcd, a_blank, a_ovf, a_busy, e_bcd, e_blank, e_ovf); end
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        #1;
        checks++; if (a_in_ready !== 1'b1) begin errors++; $display("FAIL bp_ready_path got=%b exp=1", a_in_ready); end
        @(negedge clk);
        out_ready = 1'b0;
        checks++; if (a_out_valid !== 1'b0 || a_busy !== 1'b0) begin errors++; $display("FAIL bp_taken got valid=%b busy=%b exp 0 0", a_out_valid, a_busy); end
        $display("backpressure bin=1234 bcd=%h held 5 cycles", e_bcd);
    endtask

    task automatic test_back_to_back();
        int unsigned stream[3];
        int acc_idx;
        int res_cyc[$];
        logic [15:0] res_bcd[$];
        logic [15:0] e_bcd; logic [3:0] e_blank; logic e_ovf;
        stream = '{7, 80, 905};
        acc_idx = 0;
        sel = 1'b0; out_ready = 1'b1; in_valid = 1'b1; bin = 14'(stream[0]);
        for (int cyc = 0; cyc < 80; cyc++) begin
            if (a_out_valid) begin res_cyc.push_back(cyc); res_bcd.push_back(a_bcd); end
            if (in_valid && a_in_ready) acc_idx++;
            @(posedge clk);
            #1;
            if (acc_idx < 3) bin = 14'(stream[acc_idx]);
            else in_valid = 1'b0;
            @(negedge clk);
        end
        out_ready = 1'b0;
        checks++; if (acc_idx !== 3) begin errors++; $display("FAIL b2b_accepts got=%0d exp=3", acc_idx); end
        checks++; if (res_bcd.size() !== 3) begin errors++; $display("FAIL b2b_results got=%0d exp=3", res_bcd.size()); end
        for (int i = 0; i < 3 && i < res_bcd.size(); i++) begin
            model(stream[i], e_bcd, e_blank, e_ovf);
            $display("b2b result %0d bcd=%h at cycle %0d", i, res_bcd[i], res_cyc[i]);
            checks++; if (res_bcd[i] !== e_bcd) begin errors++; $display("FAIL b2b_bcd idx=%0d got=%h exp=%h", i, res_bcd[i], e_bcd); end
            if (i > 0) begin
                checks++; if (res_cyc[i] - res_cyc[i-1] !== 13) begin errors++; $display("FAIL b2b_spacing idx=%0d got=%0d exp=13", i, res_cyc[i] - res_cyc[i-1]); end
            end
        end
    endtask

    task automatic test_wide();
        int unsigned vals[$];
        int lat;
        logic [15:0] e_bcd; logic [3:0] e_blank; logic e_ovf;
        vals = '{9999, 10000, 16383, 0, 56, 10001};
        for (int i = 0; i < 8; i++) vals.push_back($urandom_range(16383, 0));
        foreach (vals[k]) begin
            model(vals[k], e_bcd, e_blank, e_ovf);
            start_conv(1'b1, vals[k], lat);
            $display("conv14 bin=%0d bcd=%h blank=%b ovf=%b lat=%0d", vals[k], m_bcd, m_blank, m_ovf, lat);
            checks++; if (lat !== 14) begin errors++; $display("FAIL wide_latency bin=%0d got=%0d exp=14", vals[k], lat); end
            checks++; if (m_bcd !== e_bcd) begin errors++; $display("FAIL wide_bcd bin=%0d got=%h exp=%h", vals[k], m_bcd, e_bcd); end
            checks++; if (m_blank !== e_blank) begin errors++; $display("FAIL wide_blank bin=%0d got=%b exp=%b", vals[k], m_blank, e_blank); end
            checks++; if (m_ovf !== e_ovf) begin errors++; $display("FAIL wide_ovf bin=%0d got=%b exp=%b", vals[k], m_ovf, e_ovf); end
            take_result();
        end
        sel = 1'b0;
    endtask

    task automatic test_reset_abort();
        int lat;
        int bad;
        sel = 1'b0; bin = 14'd1234; in_valid = 1'b1; out_ready = 1'b0;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        checks++; if (a_busy !== 1'b1 || a_out_valid !== 1'b0) begin errors++; $display("FAIL abort_mid got busy=%b valid=%b exp 1 0", a_busy, a_out_valid); end
        rst_n = 1'b0;
        #1;
        checks++; if (a_busy !== 1'b0 || a_out_valid !== 1'b0 || a_bcd !== 16'h0 || a_blank !== 4'b0 || a_ovf !== 1'b0 || a_in_ready !== 1'b1)
            begin errors++; $display("FAIL abort_reset got busy=%b valid=%b bcd=%h blank=%b ovf=%b rdy=%b exp 0 0 0000 0000 0 1",
                                     a_busy, a_out_valid, a_bcd, a_blank, a_ovf, a_in_ready); end
        @(negedge clk);
        rst_n = 1'b1;
        bad = 0;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (a_out_valid !== 1'b0 || a_busy !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin errors++; $display("FAIL abort_no_result got=%0d active cycles exp=0", bad); end
        start_conv(1'b0, 56, lat);
        $display("after abort bin=56 bcd=%h blank=%b lat=%0d", a_bcd, a_blank, lat);
        checks++; if (lat !== 12) begin errors++; $display("FAIL abort_latency got=%0d exp=12", lat); end
        checks++; if (a_bcd !== 16'h0056 || a_blank !== 4'b1100) begin errors++; $display("FAIL abort_recover got bcd=%h blank=%b exp 0056 1100", a_bcd, a_blank); end
        take_result();
    endtask

    initial begin
        rst_n = 1'b0; sel = 1'b0; in_valid = 1'b0; out_ready = 1'b0; bin = '0;
        test_reset();
        test_conversion();
        test_backpressure();
        test_back_to_back();
        test_wide();
        test_reset_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
